wb_shared_bus: RTL and testbench
================================

// Module: wb_shared_bus
// PURPOSE
//  Parametrised Wishbone shared-bus interconnect: N_MASTERS masters, N_SLAVES slaves, one transfer at a time.
//  Round-robin arbitration; base/mask address decode; error on unmapped or hung access (timeout watchdog).
//  Successor to the fixed 8x8 conbus instance in system tops; sits between lm32 I/D ports and peripherals.
// PARAMETERS
//  N_MASTERS   2            number of masters, 1..8
//  N_SLAVES    4            number of slaves, 1..8
//  SLAVE_BASE  {..32'h0}    N_SLAVES*32 concat; slave k base at [32k+31:32k]
//  SLAVE_MASK  {..32'hF..}  N_SLAVES*32 concat; slave k hit if (adr & mask_k) == (base_k & mask_k)
//  TIMEOUT     255          cycles of stb without ack/err/rty before bus error, 2..65535
// PORTS
//  clk         in   1              system clock, all logic on rising edge
//  reset_n     in   1              synchronous, active-low reset
//  m_adr_i     in   32*N_MASTERS   master addresses (flattened, master j at [32j+31:32j])
//  m_dat_i     in   32*N_MASTERS   master write data
//  m_sel_i     in   4*N_MASTERS    master byte selects
//  m_we_i      in   N_MASTERS      master write enables
//  m_cyc_i     in   N_MASTERS      master cycle requests
//  m_stb_i     in   N_MASTERS      master strobes
//  m_dat_o     out  32             read data, broadcast to all masters
//  m_ack_o     out  N_MASTERS      per-master ack
//  m_err_o     out  N_MASTERS      per-master err (slave err, unmapped, timeout)
//  m_rty_o     out  N_MASTERS      per-master retry
//  s_adr_o     out  32             granted master address, broadcast
//  s_dat_o     out  32             granted master write data, broadcast
//  s_sel_o     out  4              granted byte selects
//  s_we_o      out  1              granted write enable
//  s_cyc_o     out  N_SLAVES       cyc, only decoded slave asserted
//  s_stb_o     out  N_SLAVES       stb, only decoded slave asserted
//  s_dat_i     in   32*N_SLAVES    slave read data
//  s_ack_i     in   N_SLAVES       slave acks
//  s_err_i     in   N_SLAVES       slave errs
//  s_rty_i     in   N_SLAVES       slave retries
//  grant_o     out  N_MASTERS      one-hot current grant (debug LEDs / probes)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE, grant_o=0, last=N_MASTERS-1, watchdog=0; all s_cyc_o/s_stb_o,
//   m_ack_o/m_err_o/m_rty_o = 0; s_adr_o/s_dat_o/s_sel_o/s_we_o/m_dat_o = 0. Reset mid-transfer aborts, no ack.
//  FSM IDLE: if any m_cyc_i, grant first requesting master after 'last' (wrapping) -> BUSY next edge.
//   Arbitration latency 1 cycle; masters never see ack in the grant cycle.
//  FSM BUSY: granted master's adr/dat/sel/we muxed onto s_* combinationally; decode picks lowest-index
//   hitting slave; that slave gets cyc=m_cyc, stb=m_stb. ack/err/rty and dat of decoded slave routed
//   combinationally to granted master only; other masters see 0. m_dat_o = decoded slave dat, else 0.
//  Grant held while granted m_cyc_i=1 (supports lm32 bursts/locked cycles). On m_cyc_i=0: last=grant,
//   -> IDLE; one dead cycle between owners.
//  Unmapped: granted stb=1 and no slave hit -> no s_cyc/s_stb; state ERR for one cycle asserting m_err_o
//   (registered, 1 cycle after stb) then back to BUSY; master must drop stb or issue new address.
//  Watchdog: 16-bit counter, increments each BUSY cycle with stb=1 and no ack/err/rty; clears on any
//   response or stb=0. At count==TIMEOUT-1 -> ERR: m_err_o pulse 1 cycle, slave stb/cyc forced 0 that
//   cycle, counter cleared.
//  Simultaneous ack+err from slave: err wins, ack suppressed. N_MASTERS=1: arbiter degenerates, still 1 cycle
//   IDLE->BUSY.
// TESTING
//  Reset: hold reset_n=0 with m_cyc_i=all 1 for 3 cycles -> all outputs 0, grant_o=0; release -> grant_o=01.
//  Fairness: 2 masters request continuously, each drops cyc after 1 ack -> grants alternate 01,10,01,10.
//  Decode: base1=32'h7000_0000 mask 32'hFFFF_0000, read 32'h7000_0004 -> s_stb_o[1]=1, m_dat_o=s_dat_i[63:32].
//  Unmapped: stb at 32'hF000_0000 -> no s_stb_o, m_err_o[j]=1 exactly one cycle later, 1 cycle wide.
//  Timeout: TIMEOUT=16, slave never acks -> m_err_o pulse at 16th stb cycle of BUSY, counter restarts.
//  Burst hold: master0 keeps cyc 4 transfers while master1 requests -> master1 granted 2 cycles after cyc drop.

Source files
------------

// File: rtl/wb_shared_bus.sv
// Wishbone shared-bus interconnect: N masters, N slaves, one transfer at a time.
// Round-robin arbitration, base/mask decode, bus error on unmapped or hung accesses.
module wb_shared_bus #(
  parameter int unsigned              N_MASTERS  = 2,
  parameter int unsigned              N_SLAVES   = 4,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE = '0,
  parameter logic [N_SLAVES*32-1:0]   SLAVE_MASK = {N_SLAVES{32'hF000_0000}},
  parameter int unsigned              TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [32*N_MASTERS-1:0] m_adr_i,
  input  logic [32*N_MASTERS-1:0] m_dat_i,
  input  logic [4*N_MASTERS-1:0]  m_sel_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  output logic [31:0]             m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic [N_MASTERS-1:0]    m_rty_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  output logic [3:0]              s_sel_o,
  output logic                    s_we_o,
  output logic [N_SLAVES-1:0]     s_cyc_o,
  output logic [N_SLAVES-1:0]     s_stb_o,
  input  logic [32*N_SLAVES-1:0]  s_dat_i,
  input  logic [N_SLAVES-1:0]     s_ack_i,
  input  logic [N_SLAVES-1:0]     s_err_i,
  input  logic [N_SLAVES-1:0]     s_rty_i,
  output logic [N_MASTERS-1:0]    grant_o
);

  localparam int unsigned MIdxW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grant_q, grant_d;
  logic [MIdxW-1:0]     last_q, last_d;
  logic [15:0]          wdog_q, wdog_d;

  logic [MIdxW-1:0]     gidx;
  logic [31:0]          g_adr, g_dat;
  logic [3:0]           g_sel;
  logic                 g_we, g_cyc, g_stb;

  logic [N_SLAVES-1:0]  slv_oh;
  logic                 hit;
  logic [31:0]          sl_dat;
  logic                 sl_ack, sl_err, sl_rty;

  logic [N_MASTERS-1:0] pick;
  logic                 found;
  logic [MIdxW-1:0]     cand;

  logic                 busy, stb_act, resp, tout, unmapped;

  // Granted master mux; everything reads as zero while nobody holds the bus.
  always_comb begin
    gidx  = '0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_we  = 1'b0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    for (int j = 0; j < int'(N_MASTERS); j++) begin
      if (grant_q[j]) begin
        gidx  = MIdxW'(j);
        g_adr = m_adr_i[32*j +: 32];
        g_dat = m_dat_i[32*j +: 32];
        g_sel = m_sel_i[4*j +: 4];
        g_we  = m_we_i[j];
        g_cyc = m_cyc_i[j];
        g_stb = m_stb_i[j];
      end
    end
  end

  // Scan downwards so the lowest-index hitting slave overrides the rest.
  always_comb begin
    slv_oh = '0;
    hit    = 1'b0;
    sl_dat = '0;
    sl_ack = 1'b0;
    sl_err = 1'b0;
    sl_rty = 1'b0;
    for (int k = int'(N_SLAVES) - 1; k >= 0; k--) begin
      if ((g_adr & SLAVE_MASK[32*k +: 32]) == (SLAVE_BASE[32*k +: 32] & SLAVE_MASK[32*k +: 32]))
      begin
        slv_oh    = '0;
        slv_oh[k] = 1'b1;
        hit       = 1'b1;
        sl_dat    = s_dat_i[32*k +: 32];
        sl_ack    = s_ack_i[k];
        sl_err    = s_err_i[k];
        sl_rty    = s_rty_i[k];
      end
    end
  end

  // Round-robin: first requester strictly after the previous owner, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= int'(N_MASTERS); i++) begin
      cand = MIdxW'((int'(last_q) + i) % int'(N_MASTERS));
      if (!found && m_cyc_i[cand]) begin
        pick[cand] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    busy     = (state_q == StBusy);
    stb_act  = busy && g_cyc && g_stb;
    resp     = hit && (sl_ack || sl_err || sl_rty);
    tout     = stb_act && hit && !resp && (wdog_q == 16'(TIMEOUT - 1));
    unmapped = stb_act && !hit;

    s_adr_o  = g_adr;
    s_dat_o  = g_dat;
    s_sel_o  = g_sel;
    s_we_o   = g_we;
    s_cyc_o  = (busy && !tout && g_cyc) ? slv_oh : '0;
    s_stb_o  = (busy && !tout && g_stb) ? slv_oh : '0;
    m_dat_o  = (busy && hit) ? sl_dat : '0;
    // Error beats a simultaneous ack.
    m_ack_o  = (busy && hit && sl_ack && !sl_err && !tout) ? grant_q : '0;
    m_err_o  = ((busy && hit && sl_err) || tout || state_q == StErr) ? grant_q : '0;
    m_rty_o  = (busy && hit && sl_rty) ? grant_q : '0;
    grant_o  = grant_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        if (found) begin
          grant_d = pick;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!g_cyc) begin
          last_d  = gidx;
          grant_d = '0;
          wdog_d  = '0;
          state_d = StIdle;
        end else if (unmapped) begin
          wdog_d  = '0;
          state_d = StErr;
        end else if (!stb_act || resp || tout) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      StErr: begin
        wdog_d  = '0;
        state_d = StBusy;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= MIdxW'(N_MASTERS - 1);
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: directed scenarios plus random transfers checked against
// an address-map / memory reference model.
module tb_wb_shared_bus;

  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 16;
  localparam logic [NS*32-1:0] BASE =
    {32'h3000_0000, 32'h3000_0000, 32'h7000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK =
    {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};

  // Address map as seen by the model, slave 0 first.
  logic [31:0] base_a [NS] = '{32'h0000_0000, 32'h7000_0000, 32'h3000_0000, 32'h3000_0000};
  logic [31:0] mask_a [NS] = '{32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000};
  logic [31:0] region [6]  = '{32'h0000_0000, 32'h7000_0000, 32'h3000_0000, 32'h3001_0000,
                               32'hF000_0000, 32'h7001_0000};

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NM*32-1:0]  m_adr, m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM-1:0]     m_we, m_cyc, m_stb;
  logic [31:0]       m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [31:0]       s_adr_o, s_dat_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic [NS*32-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;

  logic [NS-1:0]     ack_r, man_ack;
  logic              auto_en;
  logic [31:0]       smem [NS][16];
  logic [31:0]       mmem [NS][16];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wb_shared_bus #(
    .N_MASTERS  (NM),
    .N_SLAVES   (NS),
    .SLAVE_BASE (BASE),
    .SLAVE_MASK (MASK),
    .TIMEOUT    (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_we_i  (m_we),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .m_rty_o (m_rty_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_we_o  (s_we_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .s_rty_i (s_rty_i),
    .grant_o (grant_o)
  );

  function automatic logic [31:0] init_val(input int k, input int w);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_0000 + 32'(w) * 32'h0000_0101;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int exp_slave(input logic [31:0] adr);
    for (int k = 0; k < int'(NS); k++)
      if ((adr & mask_a[k]) == (base_a[k] & mask_a[k])) return k;
    return -1;
  endfunction

  // Slave models: registered single-cycle ack, small word memory.
  always @(posedge clk) begin
    for (int k = 0; k < int'(NS); k++) begin
      if (!reset_n) begin
        ack_r[k] <= 1'b0;
        for (int w = 0; w < 16; w++) smem[k][w] <= init_val(k, w);
      end else if (auto_en && s_cyc_o[k] && s_stb_o[k] && !ack_r[k]) begin
        ack_r[k] <= 1'b1;
        if (s_we_o) smem[k][s_adr_o[5:2]] <= merge(smem[k][s_adr_o[5:2]], s_dat_o, s_sel_o);
      end else begin
        ack_r[k] <= 1'b0;
      end
    end
  end

  always_comb begin
    s_dat_i = '0;
    for (int k = 0; k < int'(NS); k++) s_dat_i[32*k +: 32] = smem[k][s_adr_o[5:2]];
  end

  assign s_ack_i = ack_r | man_ack;

  task automatic model_init();
    for (int k = 0; k < int'(NS); k++)
      for (int w = 0; w < 16; w++) mmem[k][w] = init_val(k, w);
  endtask

  task automatic clear_masters();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    clear_masters();
    man_ack = '0; s_err_i = '0; s_rty_i = '0; auto_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_init();
  endtask

  // res: 1 = ack, 2 = err, 0 = no response within budget.
  task automatic do_xfer(input int m, input logic [31:0] adr, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel,
                         output int res, output logic [31:0] rdat, output int tgt);
    int c;
    res = 0; rdat = '0; tgt = -1; c = 0;
    m_adr[32*m +: 32] = adr;
    m_dat[32*m +: 32] = dat;
    m_sel[4*m +: 4]   = sel;
    m_we[m]  = we;
    m_cyc[m] = 1'b1;
    m_stb[m] = 1'b1;
    while (res == 0 && c < 40) begin
      @(negedge clk);
      for (int k = 0; k < int'(NS); k++) if (s_stb_o[k]) tgt = k;
      if (m_err_o[m]) res = 2;
      else if (m_ack_o[m]) begin
        res  = 1;
        rdat = m_dat_o;
      end
      c++;
    end
    @(posedge clk);
    #1;
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_masters();
    m_cyc = '1; m_stb = '1;
    man_ack = '0; s_err_i = '0; s_rty_i = '0; auto_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (grant_o !== '0) $display("FAIL reset_grant: got %b want 0", grant_o); else n_pass++;
    n_chk++;
    if ({s_cyc_o, s_stb_o} !== '0)
      $display("FAIL reset_slave_strobes: got %b want 0", {s_cyc_o, s_stb_o});
    else n_pass++;
    n_chk++;
    if ({m_ack_o, m_err_o, m_rty_o} !== '0)
      $display("FAIL reset_responses: got %b want 0", {m_ack_o, m_err_o, m_rty_o});
    else n_pass++;
    n_chk++;
    if ({s_adr_o, s_dat_o, s_sel_o, s_we_o, m_dat_o} !== '0)
      $display("FAIL reset_data_paths: got %h want 0", {s_adr_o, s_dat_o, s_sel_o, s_we_o, m_dat_o});
    else n_pass++;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_init();
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b00) $display("FAIL reset_idle_cycle: got %b want 00", grant_o); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (grant_o !== 2'b01) $display("FAIL reset_first_grant: got %b want 01", grant_o); else n_pass++;
    @(posedge clk);
    #1 clear_masters();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_fairness();
    logic [NM-1:0] prev, g, a, dropped;
    logic [NM-1:0] gq [$];
    int c;
    apply_reset();
    m_adr = {32'h3000_0008, 32'h0000_0004};
    m_sel = '1;
    m_cyc = '1; m_stb = '1;
    prev = '0; dropped = '0; c = 0;
    while (gq.size() < 4 && c < 60) begin
      @(negedge clk);
      g = grant_o; a = m_ack_o;
      if (g != '0 && prev == '0) gq.push_back(g);
      prev = g;
      @(posedge clk);
      #1;
      m_cyc = (m_cyc | dropped) & ~a;
      m_stb = (m_stb | dropped) & ~a;
      dropped = a;
      c++;
    end
    n_chk++;
    if (gq.size() != 4) $display("FAIL fair_grant_count: got %0d want 4", gq.size());
    else n_pass++;
    for (int i = 0; i < gq.size(); i++) begin
      n_chk++;
      if (gq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL fair_grant_%0d: got %b want %b", i, gq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
    end
    clear_masters();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_decode();
    logic [31:0] want;
    apply_reset();
    want = mmem[1][1];
    m_adr[31:0] = 32'h7000_0004;
    m_sel[3:0]  = 4'hF;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_cyc_o, s_stb_o} !== 8'b0010_0010)
      $display("FAIL decode_strobe: got %b want 00100010", {s_cyc_o, s_stb_o});
    else n_pass++;
    n_chk++;
    if (s_adr_o !== 32'h7000_0004) $display("FAIL decode_adr: got %h want 70000004", s_adr_o);
    else n_pass++;
    n_chk++;
    if (m_dat_o !== want) $display("FAIL decode_rdata: got %h want %h", m_dat_o, want);
    else n_pass++;
    n_chk++;
    if (m_ack_o !== 2'b00) $display("FAIL decode_no_early_ack: got %b want 00", m_ack_o);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (m_ack_o !== 2'b01) $display("FAIL decode_ack: got %b want 01", m_ack_o); else n_pass++;
    @(posedge clk);
    #1 clear_masters();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_unmapped();
    apply_reset();
    m_adr[63:32] = 32'hF000_0000;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({s_cyc_o, s_stb_o, m_err_o} !== '0)
      $display("FAIL unmapped_first_cycle: got %b want 0", {s_cyc_o, s_stb_o, m_err_o});
    else n_pass++;
    @(posedge clk);
    #1 m_stb[1] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m_err_o !== 2'b10) $display("FAIL unmapped_err: got %b want 10", m_err_o); else n_pass++;
    n_chk++;
    if (s_stb_o !== '0) $display("FAIL unmapped_no_stb: got %b want 0", s_stb_o); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (m_err_o !== 2'b00) $display("FAIL unmapped_err_width: got %b want 00", m_err_o);
    else n_pass++;
    @(posedge clk);
    #1 clear_masters();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    int errs [$];
    logic [NS-1:0] stb_at_err, stb_before;
    apply_reset();
    auto_en = 1'b0;
    m_adr[31:0] = 32'h0000_0010;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    stb_at_err = 'x; stb_before = 'x;
    @(negedge clk);
    for (int n = 1; n <= 34; n++) begin
      @(negedge clk);
      if (n == 15) stb_before = s_stb_o;
      if (m_err_o[0]) begin
        errs.push_back(n);
        if (errs.size() == 1) stb_at_err = s_stb_o;
      end
    end
    n_chk++;
    if (errs.size() != 2) $display("FAIL timeout_count: got %0d want 2", errs.size());
    else n_pass++;
    n_chk++;
    if (errs.size() < 1 || errs[0] != int'(TO))
      $display("FAIL timeout_first: got %0d want %0d", (errs.size() > 0) ? errs[0] : -1, TO);
    else n_pass++;
    n_chk++;
    if (errs.size() < 2 || errs[1] != 2 * int'(TO))
      $display("FAIL timeout_restart: got %0d want %0d", (errs.size() > 1) ? errs[1] : -1, 2 * TO);
    else n_pass++;
    n_chk++;
    if (stb_at_err !== '0) $display("FAIL timeout_stb_forced: got %b want 0", stb_at_err);
    else n_pass++;
    n_chk++;
    if (stb_before !== 4'b0001) $display("FAIL timeout_stb_before: got %b want 0001", stb_before);
    else n_pass++;
    @(posedge clk);
    #1 clear_masters();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_ack_err();
    apply_reset();
    auto_en = 1'b0;
    m_adr[31:0] = 32'h0000_0008;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    @(posedge clk);
    #1;
    man_ack[0] = 1'b1; s_err_i[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m_ack_o, m_err_o} !== 4'b0001)
      $display("FAIL ack_err_priority: got ack %b err %b want ack 00 err 01", m_ack_o, m_err_o);
    else n_pass++;
    @(posedge clk);
    #1;
    man_ack = '0; s_err_i = '0; s_rty_i[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 6'b00_00_01)
      $display("FAIL retry_route: got %b want 000001", {m_ack_o, m_err_o, m_rty_o});
    else n_pass++;
    @(posedge clk);
    #1;
    s_rty_i = '0;
    clear_masters();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_burst();
    int acks, bad, m1ack, c, lat;
    apply_reset();
    m_adr = {32'h7000_0000, 32'h0000_0008};
    m_sel = '1;
    m_cyc = '1; m_stb = '1;
    acks = 0; bad = 0; m1ack = 0; c = 0;
    while (acks < 4 && c < 40) begin
      @(negedge clk);
      if (c > 0 && grant_o !== 2'b01) bad++;
      if (m_ack_o[0]) acks++;
      if (m_ack_o[1]) m1ack++;
      c++;
    end
    @(posedge clk);
    #1 m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (lat == 0 && grant_o === 2'b10) lat = k;
    end
    n_chk++;
    if (acks != 4) $display("FAIL burst_acks: got %0d want 4", acks); else n_pass++;
    n_chk++;
    if (bad != 0) $display("FAIL burst_grant_held: got %0d lost cycles want 0", bad); else n_pass++;
    n_chk++;
    if (m1ack != 0) $display("FAIL burst_other_ack: got %0d want 0", m1ack); else n_pass++;
    n_chk++;
    if (lat != 2) $display("FAIL burst_handover: got %0d cycles want 2", lat); else n_pass++;
    @(posedge clk);
    #1 clear_masters();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int m, cls, w, e, res, tgt;
    logic we;
    logic [31:0] adr, dat, rdat;
    logic [3:0] sel;
    apply_reset();
    for (int t = 0; t < 48; t++) begin
      m   = $urandom_range(0, NM - 1);
      cls = $urandom_range(0, 5);
      w   = $urandom_range(0, 15);
      adr = region[cls] | (32'(w) << 2);
      we  = 1'($urandom_range(0, 1));
      dat = $urandom;
      sel = 4'($urandom_range(1, 15));
      e   = exp_slave(adr);
      do_xfer(m, adr, we, dat, sel, res, rdat, tgt);
      n_chk++;
      if (res != ((e < 0) ? 2 : 1))
        $display("FAIL rand_%0d_resp: adr %h got %0d want %0d", t, adr, res, (e < 0) ? 2 : 1);
      else n_pass++;
      n_chk++;
      if (tgt != e) $display("FAIL rand_%0d_target: adr %h got %0d want %0d", t, adr, tgt, e);
      else n_pass++;
      if (e >= 0) begin
        if (we) mmem[e][w] = merge(mmem[e][w], dat, sel);
        else begin
          n_chk++;
          if (rdat !== mmem[e][w])
            $display("FAIL rand_%0d_rdata: adr %h got %h want %h", t, adr, rdat, mmem[e][w]);
          else n_pass++;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_decode();
    test_unmapped();
    test_timeout();
    test_ack_err();
    test_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
